rsp_serializer: RTL and testbench

//  Response-path counterpart of the command parser.
//  - Pops one response packet (rsp_packet_t) from the response FIFO.
//  - Serializes it into 3 bytes, plus an optional checksum byte.
//  - Writes the bytes into the TX byte FIFO that feeds uart_tx.
//  - Sits between the register-access block's response FIFO and the UART transmit path.

---
 rtl/cmd_pkg.sv | 20 ++
 rtl/rsp_serializer.sv | 61 ++++++
 tb/tb_rsp_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command/response types, encodings and frame helpers
//  rsp_packet_t  response packet {cmd_type, status, addr, data}
//  rsp_state_e   serializer FSM states
package cmd_pkg;
   localparam logic [3:0] RSP_HDR_SYNC = 4'hA;
   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_STAT  = 2'b11;
   typedef struct packed {
      logic [1:0] cmd_type;
      logic [1:0] status;
      logic [7:0] addr;
      logic [7:0] data;
   } rsp_packet_t;
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_DATA, S_CSUM} rsp_state_e;
   function automatic logic [7:0] rsp_csum(input logic [7:0] hdr, input logic [7:0] addr, input logic [7:0] data);
      return hdr ^ addr ^ data;
   endfunction
endpackage

// File: rtl/rsp_serializer.sv
// rsp_serializer: pops response packets and writes them as 3/4-byte frames into the TX byte FIFO
//  clk, rst                            clock, async active-high reset
//  rsp_fifo_valid/rd_data/rd_en        first-word fall-through response FIFO read side
//  tx_fifo_full/wr_en/wr_data          TX byte FIFO write side
//  busy                                frame in progress
//  tx_pkt_count                        completed frames since reset (wrapping)
module rsp_serializer
   import cmd_pkg::*;
#(
   parameter logic [3:0] HDR_SYNC    = RSP_HDR_SYNC,
   parameter bit         EN_CHECKSUM = 1'b1,
   parameter int         CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rsp_fifo_valid,
   input  rsp_packet_t      rsp_fifo_rd_data,
   output logic             rsp_fifo_rd_en,
   input  logic             tx_fifo_full,
   output logic             tx_fifo_wr_en,
   output logic [7:0]       tx_fifo_wr_data,
   output logic             busy,
   output logic [CNT_W-1:0] tx_pkt_count
);
   rsp_state_e  state, nxt;
   rsp_packet_t pkt;
   logic [7:0]  hdr_byte;
   logic        frame_done;
   assign hdr_byte = {HDR_SYNC, pkt.status, pkt.cmd_type};
   assign busy = state != S_IDLE;
   // rst gates the pop so rd_en reads 0 while reset is held, even with valid high
   assign rsp_fifo_rd_en = state == S_IDLE && rsp_fifo_valid && !rst;
   assign tx_fifo_wr_en = busy && !tx_fifo_full;
   assign tx_fifo_wr_data = state == S_HDR  ? hdr_byte :
                            state == S_ADDR ? pkt.addr :
                            state == S_DATA ? pkt.data :
                            state == S_CSUM ? rsp_csum(hdr_byte, pkt.addr, pkt.data) : 8'h00;
   assign frame_done = tx_fifo_wr_en && state == (EN_CHECKSUM ? S_CSUM : S_DATA);
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  nxt = rsp_fifo_valid ? S_HDR : S_IDLE;
         S_HDR:   nxt = tx_fifo_full ? S_HDR : S_ADDR;
         S_ADDR:  nxt = tx_fifo_full ? S_ADDR : S_DATA;
         S_DATA:  nxt = tx_fifo_full ? S_DATA : (EN_CHECKSUM ? S_CSUM : S_IDLE);
         S_CSUM:  nxt = tx_fifo_full ? S_CSUM : S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         pkt          <= '0;
         tx_pkt_count <= '0;
      end else begin
         state <= nxt;
         if (rsp_fifo_rd_en) pkt <= rsp_fifo_rd_data;
         if (frame_done) tx_pkt_count <= tx_pkt_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_rsp_serializer.sv
// tb_rsp_serializer: directed checks of rsp_serializer framing, backpressure, reset and wrap
module tb_rsp_serializer;
   import cmd_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int sel = 0;
   logic vv = 1'b0;
   logic ff = 1'b0;
   rsp_packet_t dd = '0;
   logic rd0, wr0, busy0, rd1, wr1, busy1, rd2, wr2, busy2;
   logic [7:0] wd0, wd1, wd2;
   logic [15:0] cnt0, cnt1;
   logic [1:0] cnt2;
   rsp_serializer u_dut (.clk(clk), .rst(rst), .rsp_fifo_valid(vv && sel == 0), .rsp_fifo_rd_data(dd),
      .rsp_fifo_rd_en(rd0), .tx_fifo_full(ff), .tx_fifo_wr_en(wr0), .tx_fifo_wr_data(wd0),
      .busy(busy0), .tx_pkt_count(cnt0));
   rsp_serializer #(.EN_CHECKSUM(1'b0)) u_nc (.clk(clk), .rst(rst), .rsp_fifo_valid(vv && sel == 1),
      .rsp_fifo_rd_data(dd), .rsp_fifo_rd_en(rd1), .tx_fifo_full(ff), .tx_fifo_wr_en(wr1),
      .tx_fifo_wr_data(wd1), .busy(busy1), .tx_pkt_count(cnt1));
   rsp_serializer #(.CNT_W(2)) u_wrap (.clk(clk), .rst(rst), .rsp_fifo_valid(vv && sel == 2),
      .rsp_fifo_rd_data(dd), .rsp_fifo_rd_en(rd2), .tx_fifo_full(ff), .tx_fifo_wr_en(wr2),
      .tx_fifo_wr_data(wd2), .busy(busy2), .tx_pkt_count(cnt2));
   logic rd_s, wr_s;
   logic [7:0] wd_s;
   always_comb begin
      rd_s = sel == 0 ? rd0 : sel == 1 ? rd1 : rd2;
      wr_s = sel == 0 ? wr0 : sel == 1 ? wr1 : wr2;
      wd_s = sel == 0 ? wd0 : sel == 1 ? wd1 : wd2;
   end
   int cyc = 0;
   int t0 = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic [7:0] bq[$];
   int bc[$];
   int rq[$];
   logic [1:0] cq[$];
   logic [1:0] pc = 2'd0;
   logic h_en;
   logic [7:0] h_dat;
   always @(negedge clk) begin
      if (wr_s) begin
         bq.push_back(wd_s);
         bc.push_back(cyc - t0);
      end
      if (rd_s) rq.push_back(cyc - t0);
      if (cyc - t0 == 3) begin
         h_en = wr_s;
         h_dat = wd_s;
      end
      if (sel == 2 && cnt2 != pc) begin
         cq.push_back(cnt2);
         pc = cnt2;
      end
   end
   int n_chk = 0;
   int n_err = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   rsp_packet_t src[$];
   task automatic run(input int n, input logic [31:0] fm);
      bit pend = 1'b0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (pend) src.delete(0);
         if (k == 0) t0 = cyc;
         vv = src.size() != 0;
         dd = vv ? src[0] : '0;
         ff = fm[k];
         @(negedge clk);
         pend = rd_s;
      end
   endtask
   task automatic clear();
      bq.delete();
      bc.delete();
      rq.delete();
   endtask
   logic [7:0] eb[$];
   int ec[$];
   int er[$];
   task automatic chk_frames(input string tag);
      chk({tag, "_nbytes"}, bq.size(), eb.size());
      for (int i = 0; i < eb.size(); i++)
         if (i < bq.size()) begin
            chk($sformatf("%s_byte%0d", tag, i), bq[i], eb[i]);
            chk($sformatf("%s_cyc%0d", tag, i), bc[i], ec[i]);
         end
      chk({tag, "_npops"}, rq.size(), er.size());
      for (int i = 0; i < er.size(); i++)
         if (i < rq.size()) chk($sformatf("%s_pop%0d", tag, i), rq[i], er[i]);
   endtask
   localparam rsp_packet_t P1 = '{cmd_type: 2'b01, status: 2'b00, addr: 8'h3C, data: 8'h5A};
   localparam rsp_packet_t P2 = '{cmd_type: 2'b10, status: 2'b01, addr: 8'h12, data: 8'h34};
   localparam rsp_packet_t P3 = '{cmd_type: 2'b00, status: 2'b10, addr: 8'h80, data: 8'h01};
   localparam rsp_packet_t P4 = '{cmd_type: 2'b10, status: 2'b11, addr: 8'hFF, data: 8'h00};
   initial begin
      vv = 1'b1;
      dd = P1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", rd0, 1'b0);
      chk("rst_wr_en", wr0, 1'b0);
      chk("rst_wr_data", wd0, 8'h00);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_count", cnt0, 16'd0);
      vv = 1'b0;
      rst = 1'b0;
      clear();
      src = '{P1};
      run(8, 32'h0);
      eb = '{8'hA1, 8'h3C, 8'h5A, 8'hC7};
      ec = '{1, 2, 3, 4};
      er = '{0};
      chk_frames("single");
      chk("single_count", cnt0, 16'd1);
      chk("single_busy", busy0, 1'b0);
      clear();
      src = '{P1};
      run(10, 32'h1C);
      ec = '{1, 5, 6, 7};
      chk_frames("bp");
      chk("bp_hold_en", h_en, 1'b0);
      chk("bp_hold_data", h_dat, 8'h3C);
      chk("bp_count", cnt0, 16'd2);
      clear();
      src = '{P1};
      run(12, 32'hAAAAAAAA);
      ec = '{2, 4, 6, 8};
      chk_frames("toggle");
      chk("toggle_hold_data", h_dat, 8'h3C);
      chk("toggle_count", cnt0, 16'd3);
      clear();
      src = '{P1, P2, P3};
      run(17, 32'h0);
      eb = '{8'hA1, 8'h3C, 8'h5A, 8'hC7, 8'hA6, 8'h12, 8'h34, 8'h80, 8'hA8, 8'h80, 8'h01, 8'h29};
      ec = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14};
      er = '{0, 5, 10};
      chk_frames("b2b");
      chk("b2b_count", cnt0, 16'd6);
      clear();
      src = '{P2};
      run(3, 32'h0);
      @(posedge clk);
      #1;
      chk("mid_busy_pre", busy0, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", wr0, 1'b0);
      chk("mid_rst_busy", busy0, 1'b0);
      chk("mid_rst_count", cnt0, 16'd0);
      clear();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_no_writes", bq.size(), 0);
      clear();
      src = '{P3};
      run(8, 32'h0);
      eb = '{8'hA8, 8'h80, 8'h01, 8'h29};
      ec = '{1, 2, 3, 4};
      er = '{0};
      chk_frames("post_rst");
      chk("post_rst_count", cnt0, 16'd1);
      sel = 1;
      clear();
      src = '{P4, P1};
      run(10, 32'h0);
      eb = '{8'hAE, 8'hFF, 8'h00, 8'hA1, 8'h3C, 8'h5A};
      ec = '{1, 2, 3, 5, 6, 7};
      er = '{0, 4};
      chk_frames("nocsum");
      chk("nocsum_count", cnt1, 16'd2);
      sel = 2;
      clear();
      cq.delete();
      src = '{P1, P2, P3, P4, P1};
      run(30, 32'h0);
      chk("wrap_n", cq.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < cq.size()) chk($sformatf("wrap_cnt%0d", i), cq[i], (i + 1) % 4);
      chk("wrap_final", cnt2, 2'd1);
      chk("wrap_npops", rq.size(), 5);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
